vector_alu_lane_pipe: RTL and testbench

- Next-generation per-lane vector ALU: a 2-stage pipelined element engine replacing the purely combinational per-lane ALU.
- Adds a valid/ready handshake with backpressure, SEW-generic operand selection (VV/VX/VI), masking, widening add/sub, carry ops and multiply-accumulate.
- One instance per lane, between the vector register-file read stage and the lane writeback arbiter.

---
 rtl/vector_alu_lane_pipe_pkg.sv | 55 +++++
 rtl/vector_alu_lane_pipe_sew_extend.sv | 33 +++
 rtl/vector_alu_lane_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_vector_alu_lane_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_alu_lane_pipe_pkg.sv
// rtl/vector_alu_lane_pipe_pkg.sv - shared VECTOR_* opcodes, SEW and operand-type encodings
package vector_alu_lane_pipe_pkg;

    localparam logic [5:0] VECTOR_ADD   = 6'd0;
    localparam logic [5:0] VECTOR_SUB   = 6'd1;
    localparam logic [5:0] VECTOR_WADDU = 6'd2;
    localparam logic [5:0] VECTOR_WSUBU = 6'd3;
    localparam logic [5:0] VECTOR_WADD  = 6'd4;
    localparam logic [5:0] VECTOR_WSUB  = 6'd5;
    localparam logic [5:0] VECTOR_ADC   = 6'd6;
    localparam logic [5:0] VECTOR_SBC   = 6'd7;
    localparam logic [5:0] VECTOR_MSBC  = 6'd8;
    localparam logic [5:0] VECTOR_MACC  = 6'd9;
    localparam logic [5:0] VECTOR_NMSAC = 6'd10;
    localparam logic [5:0] VECTOR_MADD  = 6'd11;
    localparam logic [5:0] VECTOR_ZEXT2 = 6'd12;
    localparam logic [5:0] VECTOR_SEXT2 = 6'd13;
    localparam logic [5:0] VECTOR_ZEXT4 = 6'd14;
    localparam logic [5:0] VECTOR_SEXT4 = 6'd15;
    localparam logic [5:0] VECTOR_ZEXT8 = 6'd16;
    localparam logic [5:0] VECTOR_SEXT8 = 6'd17;

    typedef enum logic [1:0] {
        VV = 2'd0,
        VX = 2'd1,
        VI = 2'd2
    } vec_operand_e;

    typedef enum logic [2:0] {
        ONE_BYTE   = 3'd0,
        TWO_BYTE   = 3'd1,
        FOUR_BYTE  = 3'd2,
        EIGHT_BYTE = 3'd3
    } vec_sew_e;

    function automatic logic is_widening(input logic [5:0] op);
        return (op == VECTOR_WADDU) || (op == VECTOR_WSUBU) ||
               (op == VECTOR_WADD)  || (op == VECTOR_WSUB);
    endfunction

    // log2 of the extension factor k for the EXTk ops, 0 for everything else
    function automatic logic [1:0] ext_log2k(input logic [5:0] op);
        case (op)
            VECTOR_ZEXT2, VECTOR_SEXT2: return 2'd1;
            VECTOR_ZEXT4, VECTOR_SEXT4: return 2'd2;
            VECTOR_ZEXT8, VECTOR_SEXT8: return 2'd3;
            default:                    return 2'd0;
        endcase
    endfunction

    function automatic logic ext_signed(input logic [5:0] op);
        return (op == VECTOR_SEXT2) || (op == VECTOR_SEXT4) || (op == VECTOR_SEXT8);
    endfunction

endpackage

// File: rtl/vector_alu_lane_pipe_sew_extend.sv
// rtl/vector_alu_lane_pipe_sew_extend.sv - vector_sew_extend: sign/zero extend the low (8<<i_sew) bits to LEN
// Ports: i_data operand, i_sew width code (8<<code bits kept), i_signed selects sign
//        extension, o_data result. Codes wider than LEN pass i_data through unchanged.
module vector_sew_extend
    import vector_alu_lane_pipe_pkg::*;
#(
    parameter int LEN       = 64,
    parameter int SEW_WIDTH = 3
) (
    input  logic [LEN-1:0]       i_data,
    input  logic [SEW_WIDTH-1:0] i_sew,
    input  logic                 i_signed,
    output logic [LEN-1:0]       o_data
);

    int unsigned    w_width;
    logic [LEN-1:0] w_keep;
    logic           w_sign;

    always_comb begin
        w_width = 32'd8 << i_sew;
        if (w_width >= LEN) begin
            w_keep = '1;
            w_sign = 1'b0;
        end else begin
            w_keep = ~({LEN{1'b1}} << w_width);
            // top kept bit picked with a one-hot mask to avoid a variable part-select
            w_sign = i_signed & (|(i_data & ({{(LEN-1){1'b0}}, 1'b1} << (w_width - 1))));
        end
        o_data = (i_data & w_keep) | ({LEN{w_sign}} & ~w_keep);
    end

endmodule

// File: rtl/vector_alu_lane_pipe.sv
// rtl/vector_alu_lane_pipe.sv - 2-stage per-lane vector ALU with valid/ready handshake
// Ports: in_valid/in_ready/opcode/vec_operand_type/cur_vsew/vm/mask_bit/vs1/vs2/vd_old/rs/imm
//        accept one element; out_valid/out_ready/result/write_en/carry_out/err return it.
// Optional macro VECTOR_ALU_PERF_CNT_EN adds perf_ops (output transfers) and
// perf_stall (cycles with a result held by backpressure).
module vector_alu_lane_pipe
    import vector_alu_lane_pipe_pkg::*;
#(
    parameter int LEN          = 64,
    parameter int OPCODE_WIDTH = 6,
    parameter int SEW_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [1:0]              vec_operand_type,
    input  logic [SEW_WIDTH-1:0]    cur_vsew,
    input  logic                    vm,
    input  logic                    mask_bit,
    input  logic [LEN-1:0]          vs1,
    input  logic [LEN-1:0]          vs2,
    input  logic [LEN-1:0]          vd_old,
    input  logic [LEN-1:0]          rs,
    input  logic [4:0]              imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LEN-1:0]          result,
    output logic                    write_en,
    output logic                    carry_out,
    output logic                    err
`ifdef VECTOR_ALU_PERF_CNT_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_stall
`endif
);

    // stall chain: a stage advances when its downstream slot is empty or draining
    logic w_adv1, w_adv2;
    logic r_s1_valid, r_s2_valid;
    assign w_adv2   = !r_s2_valid | out_ready;
    assign w_adv1   = !r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    // ---------------- stage 1: operand select and SEW truncation ----------------
    logic [LEN-1:0] w_a_sel, w_a_trunc, w_b_trunc, w_vd_trunc;

    always_comb begin
        w_a_sel = '0;
        case (vec_operand_type)
            VV:      w_a_sel = vs1;
            VX:      w_a_sel = rs;
            VI:      w_a_sel = {{(LEN-5){imm[4]}}, imm};
            default: w_a_sel = '0;
        endcase
    end

    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_trunc_a (
        .i_data(w_a_sel), .i_sew(cur_vsew), .i_signed(1'b0), .o_data(w_a_trunc));
    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_trunc_b (
        .i_data(vs2), .i_sew(cur_vsew), .i_signed(1'b0), .o_data(w_b_trunc));
    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_trunc_vd (
        .i_data(vd_old), .i_sew(cur_vsew), .i_signed(1'b0), .o_data(w_vd_trunc));

    logic [OPCODE_WIDTH-1:0] r_s1_op;
    logic [SEW_WIDTH-1:0]    r_s1_sew;
    logic [LEN-1:0]          r_s1_a, r_s1_b, r_s1_vd;
    logic                    r_s1_we, r_s1_cin, r_s1_bad_type;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_op       <= '0;
            r_s1_sew      <= '0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_s1_vd       <= '0;
            r_s1_we       <= 1'b0;
            r_s1_cin      <= 1'b0;
            r_s1_bad_type <= 1'b0;
        end else if (w_adv1) begin
            // in_ready equals adv1 here, so a missing in_valid loads a bubble
            r_s1_valid    <= in_valid;
            r_s1_op       <= opcode;
            r_s1_sew      <= cur_vsew;
            r_s1_a        <= w_a_trunc;
            r_s1_b        <= w_b_trunc;
            r_s1_vd       <= w_vd_trunc;
            r_s1_we       <= vm | mask_bit;
            r_s1_cin      <= mask_bit;
            r_s1_bad_type <= (vec_operand_type == 2'd3);
        end
    end

    // ---------------- stage 2: compute ----------------
    logic                 w_wide, w_wide_signed, w_op_err, w_err, w_carry_raw;
    logic [1:0]           w_ext_log;
    logic [SEW_WIDTH-1:0] w_ext_code, w_final_code;
    logic [LEN-1:0]       w_wa, w_wb, w_ext, w_raw, w_res_trunc;
    logic [LEN:0]         w_adc, w_sbc, w_cpos;
    int unsigned          w_sew_bits;

    assign w_wide        = is_widening(r_s1_op);
    assign w_wide_signed = (r_s1_op == VECTOR_WADD) || (r_s1_op == VECTOR_WSUB);
    assign w_ext_log     = ext_log2k(r_s1_op);
    assign w_ext_code    = r_s1_sew - SEW_WIDTH'(w_ext_log);
    assign w_final_code  = w_wide ? r_s1_sew + SEW_WIDTH'(1) : r_s1_sew;
    assign w_sew_bits    = 32'd8 << r_s1_sew;
    // one extra bit so carry/borrow out of a full-LEN element is still visible
    assign w_adc  = {1'b0, r_s1_b} + {1'b0, r_s1_a} + {{LEN{1'b0}}, r_s1_cin};
    assign w_sbc  = {1'b0, r_s1_b} - {1'b0, r_s1_a} - {{LEN{1'b0}}, r_s1_cin};
    assign w_cpos = (LEN+1)'(1) << w_sew_bits;

    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_wide_a (
        .i_data(r_s1_a), .i_sew(r_s1_sew), .i_signed(w_wide_signed), .o_data(w_wa));
    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_wide_b (
        .i_data(r_s1_b), .i_sew(r_s1_sew), .i_signed(w_wide_signed), .o_data(w_wb));
    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_ext (
        .i_data(r_s1_b), .i_sew(w_ext_code), .i_signed(ext_signed(r_s1_op)), .o_data(w_ext));
    vector_sew_extend #(.LEN(LEN), .SEW_WIDTH(SEW_WIDTH)) u_trunc_res (
        .i_data(w_raw), .i_sew(w_final_code), .i_signed(1'b0), .o_data(w_res_trunc));

    always_comb begin
        w_raw       = '0;
        w_carry_raw = 1'b0;
        w_op_err    = 1'b0;
        case (r_s1_op)
            VECTOR_ADD:                 w_raw = r_s1_a + r_s1_b;
            VECTOR_SUB:                 w_raw = r_s1_b - r_s1_a;
            VECTOR_WADDU, VECTOR_WADD:  w_raw = w_wa + w_wb;
            VECTOR_WSUBU, VECTOR_WSUB:  w_raw = w_wb - w_wa;
            VECTOR_ADC: begin
                w_raw       = w_adc[LEN-1:0];
                w_carry_raw = |(w_adc & w_cpos);
            end
            VECTOR_SBC: begin
                w_raw       = w_sbc[LEN-1:0];
                w_carry_raw = |(w_sbc & w_cpos);
            end
            VECTOR_MSBC:                w_carry_raw = |(w_sbc & w_cpos);
            VECTOR_MACC:                w_raw = r_s1_vd + r_s1_a * r_s1_b;
            VECTOR_NMSAC:               w_raw = r_s1_vd - r_s1_a * r_s1_b;
            VECTOR_MADD:                w_raw = r_s1_a * r_s1_vd + r_s1_b;
            VECTOR_ZEXT2, VECTOR_SEXT2, VECTOR_ZEXT4,
            VECTOR_SEXT4, VECTOR_ZEXT8, VECTOR_SEXT8: begin
                w_raw    = w_ext;
                // source field SEW/k would be narrower than a byte
                w_op_err = r_s1_sew < SEW_WIDTH'(w_ext_log);
            end
            default:                    w_op_err = 1'b1;
        endcase
        if (w_wide && (r_s1_sew == EIGHT_BYTE || (32'd16 << r_s1_sew) > 32'(LEN)))
            w_op_err = 1'b1;
    end

    assign w_err = r_s1_bad_type | (r_s1_sew > EIGHT_BYTE) | w_op_err;

    logic           r_s2_we, r_s2_carry, r_s2_err;
    logic [LEN-1:0] r_s2_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_we     <= 1'b0;
            r_s2_carry  <= 1'b0;
            r_s2_err    <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= w_err;
            if (w_err) begin
                // erroring elements still flow out to keep ordering
                r_s2_result <= '0;
                r_s2_we     <= 1'b0;
                r_s2_carry  <= 1'b0;
            end else if (!r_s1_we) begin
                // masked-off: pass the old destination value through undisturbed
                r_s2_result <= r_s1_vd;
                r_s2_we     <= 1'b0;
                r_s2_carry  <= 1'b0;
            end else begin
                r_s2_result <= w_res_trunc;
                r_s2_we     <= 1'b1;
                r_s2_carry  <= w_carry_raw;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_s2_result;
    assign write_en  = r_s2_we;
    assign carry_out = r_s2_carry;
    assign err       = r_s2_err;

`ifdef VECTOR_ALU_PERF_CNT_EN
    logic [31:0] r_perf_ops, r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_ops   <= r_perf_ops + {31'd0, r_s2_valid & out_ready};
            r_perf_stall <= r_perf_stall + {31'd0, r_s2_valid & !out_ready};
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_vector_alu_lane_pipe.sv
// tb/tb_vector_alu_lane_pipe.sv - self-checking bench for vector_alu_lane_pipe
module tb_vector_alu_lane_pipe;
    import vector_alu_lane_pipe_pkg::*;

    localparam int LEN = 64;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, vm, mask_bit, out_valid, out_ready;
    logic        write_en, carry_out, err;
    logic [5:0]  opcode;
    logic [1:0]  vec_operand_type;
    logic [2:0]  cur_vsew;
    logic [63:0] vs1, vs2, vd_old, rs, result;
    logic [4:0]  imm;
`ifdef VECTOR_ALU_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    always #5 clk = ~clk;

    vector_alu_lane_pipe #(.LEN(LEN), .OPCODE_WIDTH(6), .SEW_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .vec_operand_type(vec_operand_type), .cur_vsew(cur_vsew),
        .vm(vm), .mask_bit(mask_bit), .vs1(vs1), .vs2(vs2), .vd_old(vd_old),
        .rs(rs), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .write_en(write_en), .carry_out(carry_out), .err(err)
`ifdef VECTOR_ALU_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [5:0]  op;
        logic [1:0]  typ;
        logic [2:0]  sew;
        logic        vm;
        logic        mask;
        logic [63:0] vs1, vs2, vd, rs;
        logic [4:0]  imm;
    } bundle_t;

    typedef struct {
        logic [63:0] res;
        logic        we;
        logic        carry;
        logic        err;
        int          cyc;
    } obs_t;

    bundle_t stim_q[$];
    bundle_t acc_q[$];
    int      acc_cyc[$];
    obs_t    obs_q[$];
    int      total = 0;
    int      bad = 0;

    function automatic bundle_t mk(input logic [5:0] op, input logic [1:0] typ, input logic [2:0] sew,
                                   input logic v, input logic m, input logic [63:0] a1,
                                   input logic [63:0] a2, input logic [63:0] vd, input logic [63:0] r,
                                   input logic [4:0] im);
        bundle_t b;
        b.op = op; b.typ = typ; b.sew = sew; b.vm = v; b.mask = m;
        b.vs1 = a1; b.vs2 = a2; b.vd = vd; b.rs = r; b.imm = im;
        return b;
    endfunction

    function automatic logic [127:0] lowmask(input int bits);
        return (bits >= 128) ? {128{1'b1}} : ((128'(1) << bits) - 128'(1));
    endfunction

    function automatic logic [127:0] sx(input logic [127:0] x, input int bits);
        if (((x >> (bits - 1)) & 128'(1)) != 0) return x | ~lowmask(bits);
        return x & lowmask(bits);
    endfunction

    // reference: the element operation written as wide-integer arithmetic
    function automatic obs_t model(input bundle_t b);
        obs_t e;
        int bits, k, sub;
        logic [127:0] m, m2, a, v2, vd, full, cin;
        logic illegal, sgn;
        e.res = '0; e.we = 1'b0; e.carry = 1'b0; e.err = 1'b0; e.cyc = 0;
        bits = 8 << b.sew;
        m = lowmask(bits);
        m2 = lowmask(2 * bits);
        case (b.typ)
            2'd0:    a = 128'(b.vs1);
            2'd1:    a = 128'(b.rs);
            2'd2:    a = sx(128'(b.imm), 5);
            default: a = '0;
        endcase
        a = a & m; v2 = 128'(b.vs2) & m; vd = 128'(b.vd) & m; cin = 128'(b.mask);
        illegal = (b.typ == 2'd3) || (b.sew > 3'd3);
        full = '0; k = 0; sgn = 1'b0;
        case (b.op)
            VECTOR_ADD:   full = (a + v2) & m;
            VECTOR_SUB:   full = (v2 - a) & m;
            VECTOR_WADDU: full = (a + v2) & m2;
            VECTOR_WSUBU: full = (v2 - a) & m2;
            VECTOR_WADD:  full = (sx(a, bits) + sx(v2, bits)) & m2;
            VECTOR_WSUB:  full = (sx(v2, bits) - sx(a, bits)) & m2;
            VECTOR_ADC: begin
                full = (v2 + a + cin) & m;
                e.carry = (((v2 + a + cin) >> bits) & 128'(1)) != 0;
            end
            VECTOR_SBC: begin
                full = (v2 - a - cin) & m;
                e.carry = v2 < (a + cin);
            end
            VECTOR_MSBC:  e.carry = v2 < (a + cin);
            VECTOR_MACC:  full = (vd + a * v2) & m;
            VECTOR_NMSAC: full = (vd - a * v2) & m;
            VECTOR_MADD:  full = (a * vd + v2) & m;
            VECTOR_ZEXT2: k = 2;
            VECTOR_SEXT2: begin k = 2; sgn = 1'b1; end
            VECTOR_ZEXT4: k = 4;
            VECTOR_SEXT4: begin k = 4; sgn = 1'b1; end
            VECTOR_ZEXT8: k = 8;
            VECTOR_SEXT8: begin k = 8; sgn = 1'b1; end
            default:      illegal = 1'b1;
        endcase
        if (b.op inside {VECTOR_WADDU, VECTOR_WSUBU, VECTOR_WADD, VECTOR_WSUB} && 2 * bits > LEN)
            illegal = 1'b1;
        if (k != 0) begin
            sub = bits / k;
            if (sub < 8) illegal = 1'b1;
            else full = (sgn ? sx(v2 & lowmask(sub), sub) : (v2 & lowmask(sub))) & m;
        end
        if (illegal) begin
            e.err = 1'b1; e.carry = 1'b0;
        end else if (!(b.vm | b.mask)) begin
            e.res = vd[63:0]; e.carry = 1'b0;
        end else begin
            e.res = full[63:0]; e.we = 1'b1;
        end
        return e;
    endfunction

    function automatic bundle_t rand_bundle();
        logic [5:0] ops [18] = '{VECTOR_ADD, VECTOR_SUB, VECTOR_WADDU, VECTOR_WSUBU, VECTOR_WADD,
                                 VECTOR_WSUB, VECTOR_ADC, VECTOR_SBC, VECTOR_MSBC, VECTOR_MACC,
                                 VECTOR_NMSAC, VECTOR_MADD, VECTOR_ZEXT2, VECTOR_SEXT2,
                                 VECTOR_ZEXT4, VECTOR_SEXT4, VECTOR_ZEXT8, VECTOR_SEXT8};
        bundle_t b;
        b.op   = ($urandom_range(0, 19) == 0) ? 6'd50 : ops[$urandom_range(0, 17)];
        b.typ  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        b.sew  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        b.vm   = $urandom_range(0, 3) != 0;
        b.mask = 1'($urandom);
        b.vs1  = {$urandom, $urandom};
        b.vs2  = {$urandom, $urandom};
        b.vd   = {$urandom, $urandom};
        b.rs   = {$urandom, $urandom};
        b.imm  = 5'($urandom);
        return b;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stim_q.delete(); acc_q.delete(); acc_cyc.delete(); obs_q.delete();
    endtask

    task automatic drive(input bundle_t b);
        opcode = b.op; vec_operand_type = b.typ; cur_vsew = b.sew; vm = b.vm;
        mask_bit = b.mask; vs1 = b.vs1; vs2 = b.vs2; vd_old = b.vd; rs = b.rs; imm = b.imm;
    endtask

    // drives stim_q through the DUT and records transfers; ready_mode 0=always, 1=random, 2=low 3 cycles
    task automatic run_stream(input int max_cycles, input int ready_mode);
        int cyc = 0;
        while (cyc < max_cycles && !(stim_q.size() == 0 && obs_q.size() == acc_q.size() && cyc > 0)) begin
            @(negedge clk);
            if (stim_q.size() > 0) begin
                drive(stim_q[0]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            case (ready_mode)
                1:       out_ready = $urandom_range(0, 2) != 0;
                2:       out_ready = cyc >= 3;
                default: out_ready = 1'b1;
            endcase
            #1;
            if (out_valid && out_ready)
                obs_q.push_back('{result, write_en, carry_out, err, cyc});
            if (in_valid && in_ready) begin
                acc_q.push_back(stim_q.pop_front());
                acc_cyc.push_back(cyc);
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 64'd0 || write_en !== 1'b0 || carry_out !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got res=%h we=%b c=%b err=%b want all 0", result, write_en, carry_out, err);
        end
    endtask

    task automatic test_add_latency();
        apply_reset();
        stim_q.push_back(mk(VECTOR_ADD, 2'd0, 3'd0, 1'b1, 1'b0, 64'hFF, 64'h02, 64'h0, 64'h0, 5'd0));
        run_stream(20, 0);
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL add_count: got %0d want 1", obs_q.size()); end
        else begin
            total++; if (obs_q[0].res !== 64'h01 || obs_q[0].we !== 1'b1 || obs_q[0].err !== 1'b0) begin
                bad++; $display("FAIL add_result: got res=%h we=%b err=%b want res=01 we=1 err=0", obs_q[0].res, obs_q[0].we, obs_q[0].err);
            end
            total++; if (obs_q[0].cyc - acc_cyc[0] != 2) begin
                bad++; $display("FAIL add_latency: got %0d want 2", obs_q[0].cyc - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_widen();
        apply_reset();
        stim_q.push_back(mk(VECTOR_WADD, 2'd0, 3'd1, 1'b1, 1'b0, 64'h8000, 64'hFFFF, 64'h0, 64'h0, 5'd0));
        stim_q.push_back(mk(VECTOR_WADD, 2'd0, 3'd3, 1'b1, 1'b0, 64'h8000, 64'hFFFF, 64'h0, 64'h0, 5'd0));
        run_stream(20, 0);
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL widen_count: got %0d want 2", obs_q.size()); end
        else begin
            total++; if (obs_q[0].res !== 64'hFFFF_7FFF || obs_q[0].err !== 1'b0 || obs_q[0].we !== 1'b1) begin
                bad++; $display("FAIL wadd_16: got res=%h err=%b we=%b want res=ffff7fff err=0 we=1", obs_q[0].res, obs_q[0].err, obs_q[0].we);
            end
            total++; if (obs_q[1].res !== 64'd0 || obs_q[1].err !== 1'b1 || obs_q[1].we !== 1'b0) begin
                bad++; $display("FAIL wadd_64_err: got res=%h err=%b we=%b want res=0 err=1 we=0", obs_q[1].res, obs_q[1].err, obs_q[1].we);
            end
        end
    endtask

    task automatic test_adc_and_mask();
        apply_reset();
        stim_q.push_back(mk(VECTOR_ADC, 2'd2, 3'd2, 1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF, 64'h0, 64'h0, 5'd0));
        stim_q.push_back(mk(VECTOR_ADD, 2'd0, 3'd1, 1'b0, 1'b0, 64'h11, 64'h22, 64'h1234, 64'h0, 5'd0));
        run_stream(20, 0);
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL adc_mask_count: got %0d want 2", obs_q.size()); end
        else begin
            total++; if (obs_q[0].res !== 64'd0 || obs_q[0].carry !== 1'b1 || obs_q[0].we !== 1'b1) begin
                bad++; $display("FAIL adc_carry: got res=%h c=%b we=%b want res=0 c=1 we=1", obs_q[0].res, obs_q[0].carry, obs_q[0].we);
            end
            total++; if (obs_q[1].res !== 64'h1234 || obs_q[1].we !== 1'b0) begin
                bad++; $display("FAIL masked: got res=%h we=%b want res=1234 we=0", obs_q[1].res, obs_q[1].we);
            end
        end
    endtask

    task automatic test_backpressure();
        bundle_t sent[4];
        obs_t e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            sent[i] = rand_bundle();
            sent[i].op = VECTOR_MACC; sent[i].typ = 2'd0; sent[i].vm = 1'b1;
            sent[i].sew = 3'($urandom_range(0, 3));
            stim_q.push_back(sent[i]);
        end
        run_stream(40, 2);
        total++;
        if (acc_cyc.size() != 4 || acc_cyc[1] != 1 || acc_cyc[2] != 3) begin
            bad++; $display("FAIL bp_in_ready: accepts=%0d second=%0d third=%0d want 4,1,3",
                            acc_cyc.size(), acc_cyc.size() > 1 ? acc_cyc[1] : -1, acc_cyc.size() > 2 ? acc_cyc[2] : -1);
        end
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", obs_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                e = model(sent[i]);
                total++;
                if (obs_q[i].res !== e.res || obs_q[i].we !== e.we || obs_q[i].err !== e.err) begin
                    bad++; $display("FAIL bp_elem%0d: got res=%h we=%b err=%b want res=%h we=%b err=%b",
                                    i, obs_q[i].res, obs_q[i].we, obs_q[i].err, e.res, e.we, e.err);
                end
            end
        end
    endtask

    task automatic test_random();
        bundle_t sent[$];
        obs_t e;
        int n = 150;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            sent.push_back(rand_bundle());
            stim_q.push_back(sent[i]);
        end
        run_stream(3000, 1);
        total++;
        if (obs_q.size() != n) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), n); end
        else begin
            for (int i = 0; i < n; i++) begin
                e = model(sent[i]);
                total++;
                if (obs_q[i].res !== e.res || obs_q[i].we !== e.we || obs_q[i].carry !== e.carry || obs_q[i].err !== e.err) begin
                    bad++; $display("FAIL rand_elem%0d op=%0d sew=%0d typ=%0d: got res=%h we=%b c=%b err=%b want res=%h we=%b c=%b err=%b",
                                    i, sent[i].op, sent[i].sew, sent[i].typ, obs_q[i].res, obs_q[i].we,
                                    obs_q[i].carry, obs_q[i].err, e.res, e.we, e.carry, e.err);
                end
            end
        end
`ifdef VECTOR_ALU_PERF_CNT_EN
        #1;
        total++; if (perf_ops !== 32'(n)) begin bad++; $display("FAIL perf_ops: got %0d want %0d", perf_ops, n); end
`endif
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(mk(VECTOR_ADD, 2'd0, 3'd0, 1'b1, 1'b0, 64'(i), 64'h5, 64'h0, 64'h0, 5'd0));
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL full_before_rst: got out_valid=%b in_ready=%b want 1,0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_midflight: got out_valid=%b in_ready=%b want 0,1", out_valid, in_ready);
        end
`ifdef VECTOR_ALU_PERF_CNT_EN
        total++; if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
            bad++; $display("FAIL perf_clear: got ops=%0d stall=%0d want 0,0", perf_ops, perf_stall);
        end
`endif
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(6'd0, 2'd0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0));
        test_reset();
        test_add_latency();
        test_widen();
        test_adc_and_mask();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
